// File: rtl/alu_exec_ctrl.sv
// Instruction sequencer for an external 4-bit ALU: accepts one instruction at a time,
// holds the ALU operands for ALU_LAT cycles and retires results into acc and the flags.
module alu_exec_ctrl #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] opcode,
  input  logic [3:0] operand,
  output logic [2:0] alu_f,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_y,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic [3:0] acc,
  output logic       c_flag,
  output logic       z_flag,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(ALU_LAT - 1);

  state_t     state;
  logic [1:0] cnt;

  assign instr_ready = (state == IDLE);
  assign alu_a       = acc;

  // Non-ALU opcodes take effect on the accepting edge so their result is visible in WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      alu_f  <= '0;
      alu_b  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            alu_f <= opcode[2:0];
            alu_b <= operand;
            cnt   <= '0;
            if (!opcode[3]) begin
              state <= EXEC;
            end else begin
              state <= WB;
              case (opcode[2:0])
                3'b000: begin
                  acc    <= operand;
                  z_flag <= (operand == 4'd0);
                  done   <= 1'b1;
                end
                3'b001: done <= 1'b1;
                3'b010: begin
                  c_flag <= 1'b0;
                  z_flag <= 1'b0;
                  done   <= 1'b1;
                end
                default: err <= 1'b1;
              endcase
            end
          end
        end
        EXEC: begin
          if (cnt == CNT_LAST) begin
            state  <= WB;
            acc    <= alu_y;
            c_flag <= alu_carry;
            z_flag <= alu_zero;
            done   <= 1'b1;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter: ALU_LAT, default 1, cycles the ALU inputs are held before its outputs are sampled; legal range 1..3.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  upstream instruction present.
REQ-005 instr_ready  output  1  block can accept an instruction.
REQ-006 opcode  input  4  instruction opcode.
REQ-007 operand  input  4  immediate operand / ALU B operand.
REQ-008 alu_f  output  3  ALU function select.
REQ-009 alu_a  output  4  ALU A operand.
REQ-010 alu_b  output  4  ALU B operand.
REQ-011 alu_y  input  4  ALU result.
REQ-012 alu_carry  input  1  ALU carry out.
REQ-013 alu_zero  input  1  ALU zero flag.
REQ-014 acc  output  4  accumulator.
REQ-015 c_flag  output  1  registered carry flag.
REQ-016 z_flag  output  1  registered zero flag.
REQ-017 done  output  1  one-cycle pulse: instruction retired.
REQ-018 err  output  1  one-cycle pulse: illegal opcode retired.

Function
REQ-019 States SHALL be IDLE, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-020 Handshake: transfer occurs when instr_valid=1 and instr_ready=1 on a rising edge; opcode and operand SHALL be latched at that edge, and later input changes SHALL be ignored until the next transfer.
REQ-021 Opcode map: 0xxx = ALU op with alu_f=opcode[2:0]; 1000 = LDI; 1001 = NOP; 1010 = CLRF; 1011-1111 = illegal.
REQ-022 ALU op: IDLE->EXEC on transfer; in EXEC a cycle counter SHALL run for exactly ALU_LAT cycles, then go to WB.
REQ-023 Non-ALU ops (LDI, NOP, CLRF, illegal): IDLE->WB on transfer, skipping EXEC.
REQ-024 WB SHALL last exactly one cycle, then go to IDLE.
REQ-025 alu_a SHALL equal acc at all times; alu_f and alu_b SHALL be registered from the latched opcode[2:0] and operand at transfer and held stable through EXEC.
REQ-026 ALU op: on the edge leaving EXEC, acc <= alu_y, c_flag <= alu_carry, z_flag <= alu_zero.
REQ-027 LDI: on the edge leaving IDLE, acc <= operand, z_flag <= (operand==0); c_flag SHALL be unchanged.
REQ-028 CLRF: c_flag <= 0 and z_flag <= 0; acc SHALL be unchanged. NOP SHALL change no register.
REQ-029 Illegal opcode: acc, c_flag, z_flag SHALL be unchanged; err SHALL be 1 in WB.
REQ-030 done SHALL be 1 in WB for every legal opcode, and 0 for illegal opcodes; updated acc and flags SHALL already be visible in the WB cycle.
REQ-031 Latency: ALU op accepted at edge T -> done high in cycle T+ALU_LAT+1 -> instr_ready high at T+ALU_LAT+2; non-ALU op -> done/err at T+1, ready at T+2.
REQ-032 Back-to-back operation: a new transfer SHALL be possible in the first IDLE cycle after WB; throughput SHALL be at most one instruction per ALU_LAT+2 cycles.
REQ-033 Arithmetic SHALL be 4-bit; no internal overflow handling beyond the captured alu_carry.

Reset
REQ-034 While reset=1 at an edge: state <= IDLE; acc, c_flag, z_flag, alu_f, alu_b, and the counter <= 0; done and err <= 0.
REQ-035 Reset SHALL take priority over a simultaneous transfer; that instruction SHALL be discarded.
REQ-036 Reset asserted in EXEC or WB SHALL abort the instruction: no register update and no done/err pulse after reset.
REQ-037 instr_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-038 Reset, then LDI operand=0000 -> acc=0000, z_flag=1, c_flag=0, done pulse at T+1.
REQ-039 LDI 0101, then ALU op opcode=0000 operand=0011 with ALU_LAT=2 and stub alu_y=1000/carry=1/zero=0 -> alu_a=0101, alu_b=0011, alu_f=000 held 2 cycles; then acc=1000, c=1, z=0, done at T+3.
REQ-040 With c=1 and z=1, CLRF -> c=0, z=0, acc unchanged, done pulse; then opcode 1100 -> err pulse, no done, registers unchanged.
REQ-041 instr_valid held high with changing opcode during EXEC -> instr_ready=0, changes ignored, only one retirement per transfer.
REQ-042 Reset asserted in the middle of EXEC -> next cycle IDLE, acc=0, flags=0, no done pulse, instr_ready=1 after deassertion.
